// File: rtl/spike_tx_if.sv
// Write-side FIFO port and 4-phase bundled-data token port of spike_tx.
// slave is the transmitter's view; master is the host/neuron side.
interface spike_tx_if #(
    parameter int unsigned data_bits = 4
);
    logic [data_bits-1:0] wr_data;
    logic                 wr_valid;
    logic                 wr_ready;
    logic [data_bits-1:0] data_out;
    logic                 req_out;
    logic                 ack_in;

    modport slave (
        input  wr_data, wr_valid, ack_in,
        output wr_ready, data_out, req_out
    );

    modport master (
        output wr_data, wr_valid, ack_in,
        input  wr_ready, data_out, req_out
    );
endinterface

// File: rtl/spike_tx.sv
// Clocked initiator of return-to-zero tokens for the neuron handshake:
// buffers host words in a small FIFO and sends each one as one token.
module spike_tx #(
    parameter int unsigned data_bits    = 4,
    parameter int unsigned fifo_depth   = 4,
    parameter int unsigned setup_cycles = 1,
    parameter int unsigned sync_stages  = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    spike_tx_if.slave     tx,
    output logic          busy_o,
    output logic [15:0]   sent_count_o
);
    localparam int unsigned AW = $clog2(fifo_depth);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        REQ_HI,
        REQ_LO
    } state_e;

    state_e                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic                     req_q, req_d;
    logic [data_bits-1:0]     dout_q, dout_d;
    logic [15:0]              sent_q, sent_d;
    logic                     busy_q, busy_d;
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            occ_q, occ_d;
    logic [sync_stages-1:0]   sync_q, sync_d;
    logic [data_bits-1:0]     mem [fifo_depth];

    logic                     ack_s;
    logic                     wr_ready;
    logic                     push;
    logic                     pop;

    assign ack_s    = sync_q[sync_stages-1];
    assign wr_ready = (occ_q < CW'(fifo_depth));
    assign push     = tx.wr_valid && wr_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        dout_d   = dout_q;
        sent_d   = sent_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        pop      = 1'b0;
        sync_d   = {sync_q[sync_stages-2:0], tx.ack_in};
        busy_d   = (occ_q != '0) || (state_q != IDLE);

        case (state_q)
            IDLE: begin
                // ack_s low guard also holds off a new token after a
                // reset that interrupted a handshake.
                if (occ_q != '0 && !ack_s) begin
                    pop    = 1'b1;
                    dout_d = mem[rd_ptr_q];
                    if (setup_cycles == 0) begin
                        req_d   = 1'b1;
                        state_d = REQ_HI;
                    end else begin
                        cnt_d   = 4'(setup_cycles);
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    req_d   = 1'b1;
                    state_d = REQ_HI;
                end
            end
            REQ_HI: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = REQ_LO;
                end
            end
            REQ_LO: begin
                if (!ack_s) begin
                    sent_d  = sent_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            dout_q   <= '0;
            sent_q   <= '0;
            busy_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            sync_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            dout_q   <= dout_d;
            sent_q   <= sent_d;
            busy_q   <= busy_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            sync_q   <= sync_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= tx.wr_data;
    end

    assign tx.wr_ready   = wr_ready;
    assign tx.data_out   = dout_q;
    assign tx.req_out    = req_q;
    assign busy_o        = busy_q;
    assign sent_count_o  = sent_q;
endmodule

// File: tb/tb_spike_tx.sv
// Directed bench for spike_tx: default instance plus a zero-setup instance
// used for the same-edge request and count wrap checks.
module tb_spike_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy, busy0;
    logic [15:0] cnt, cnt0;

    always #5 clk = ~clk;

    spike_tx_if #(.data_bits(4)) bus ();
    spike_tx_if #(.data_bits(4)) bus0 ();

    spike_tx #(
        .data_bits(4), .fifo_depth(4), .setup_cycles(1), .sync_stages(2)
    ) dut (
        .clk_i(clk), .rst_i(rst), .tx(bus.slave),
        .busy_o(busy), .sent_count_o(cnt)
    );

    spike_tx #(
        .data_bits(4), .fifo_depth(4), .setup_cycles(0), .sync_stages(2)
    ) dut0 (
        .clk_i(clk), .rst_i(rst), .tx(bus0.slave),
        .busy_o(busy0), .sent_count_o(cnt0)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned stab_errs = 0;
    int unsigned rises = 0;
    logic        req_prev = 1'b0;
    logic [3:0]  exp_q [$];

    // Request rising edges, used to catch extra or missing tokens.
    always @(negedge clk) begin
        if (bus.req_out === 1'b1 && req_prev === 1'b0) rises++;
        req_prev <= bus.req_out;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ack);
        bus.ack_in    = ack;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus0.ack_in   = 1'b0;
        bus0.wr_valid = 1'b0;
        bus0.wr_data  = '0;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic write_word(input logic [3:0] v);
        bus.wr_data  = v;
        bus.wr_valid = 1'b1;
        tick;
        bus.wr_valid = 1'b0;
    endtask

    task automatic serve_token(input int unsigned dly, output logic [3:0] got);
        logic [15:0] c0;
        int unsigned n;
        c0 = cnt;
        n  = 0;
        while (bus.req_out !== 1'b1 && n < 200) begin tick; n++; end
        if (n >= 200) check("req_rise_timeout", {31'd0, bus.req_out}, 32'd1);
        got = bus.data_out;
        repeat (dly) begin
            tick;
            if (bus.data_out !== got || bus.req_out !== 1'b1) stab_errs++;
        end
        bus.ack_in = 1'b1;
        n = 0;
        while (bus.req_out !== 1'b0 && n < 200) begin
            tick; n++;
            if (bus.data_out !== got) stab_errs++;
        end
        if (n >= 200) check("req_fall_timeout", {31'd0, bus.req_out}, 32'd0);
        repeat (dly) begin
            tick;
            if (bus.data_out !== got || bus.req_out !== 1'b0) stab_errs++;
        end
        bus.ack_in = 1'b0;
        n = 0;
        while (cnt == c0 && n < 200) begin
            tick; n++;
            if (bus.data_out !== got || bus.req_out !== 1'b0) stab_errs++;
        end
        if (n >= 200) check("count_inc_timeout", {16'd0, cnt}, {16'd0, c0 + 16'd1});
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, failed %0d", n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  got;
        int unsigned spur;
        int unsigned r0;
        int unsigned order_errs;

        // Reset state
        do_reset(1'b0);
        check("rst_req",   {31'd0, bus.req_out},  32'd0);
        check("rst_data",  {28'd0, bus.data_out}, 32'd0);
        check("rst_count", {16'd0, cnt},          32'd0);
        check("rst_ready", {31'd0, bus.wr_ready}, 32'd1);
        check("rst_busy",  {31'd0, busy},         32'd0);

        // Single token, hand-timed against edges e0..e9
        write_word(4'h5);                                       // e0
        check("t1_e0_data", {28'd0, bus.data_out}, 32'd0);
        tick;                                                   // e1: pop
        check("t1_e1_data", {28'd0, bus.data_out}, 32'h5);
        check("t1_e1_req",  {31'd0, bus.req_out},  32'd0);
        check("t1_e1_busy", {31'd0, busy},         32'd1);
        tick;                                                   // e2: req up
        check("t1_e2_req",  {31'd0, bus.req_out},  32'd1);
        bus.ack_in = 1'b1;
        tick; tick;                                             // e3, e4
        check("t1_e4_req",  {31'd0, bus.req_out},  32'd1);
        tick;                                                   // e5: req down
        check("t1_e5_req",  {31'd0, bus.req_out},  32'd0);
        bus.ack_in = 1'b0;
        tick; tick;                                             // e6, e7
        check("t1_e7_count", {16'd0, cnt}, 32'd0);
        tick;                                                   // e8: count
        check("t1_e8_count", {16'd0, cnt}, 32'd1);
        tick;                                                   // e9
        check("t1_e9_busy", {31'd0, busy},         32'd0);
        check("t1_e9_data", {28'd0, bus.data_out}, 32'h5);

        // Stuck ack: no token while ack is held, then a normal token
        do_reset(1'b1);
        tick; tick;
        write_word(4'h7);
        spur = 0;
        repeat (10) begin
            tick;
            if (bus.req_out !== 1'b0) spur++;
        end
        check("stuck_no_req",  spur, 0);
        check("stuck_no_pop",  {28'd0, bus.data_out}, 32'd0);
        bus.ack_in = 1'b0;
        serve_token(0, got);
        check("stuck_data",  {28'd0, got}, 32'h7);
        check("stuck_count", {16'd0, cnt}, 32'd1);

        // Burst with ack held so the FIFO fills; fifth write is dropped
        do_reset(1'b1);
        tick; tick;
        for (int unsigned i = 1; i <= 5; i++) begin
            write_word(4'(i));
            if (i == 3) check("burst_ready_3", {31'd0, bus.wr_ready}, 32'd1);
            if (i == 4) check("burst_ready_4", {31'd0, bus.wr_ready}, 32'd0);
        end
        check("burst_busy", {31'd0, busy}, 32'd1);
        bus.ack_in = 1'b0;
        r0 = rises;
        for (int unsigned i = 1; i <= 4; i++) begin
            serve_token(1, got);
            check($sformatf("burst_order_%0d", i), {28'd0, got}, i);
        end
        repeat (20) tick;
        check("burst_count", {16'd0, cnt},         32'd4);
        check("burst_rises", rises - r0,           32'd4);
        check("burst_idle",  {31'd0, busy},        32'd0);
        check("burst_ready", {31'd0, bus.wr_ready}, 32'd1);

        // Random responder delays over 200 tokens
        do_reset(1'b0);
        r0 = rises;
        stab_errs = 0;
        order_errs = 0;
        fork
            begin
                for (int unsigned i = 0; i < 200; i++) begin
                    logic        acc;
                    logic [3:0]  v;
                    int unsigned n;
                    v = 4'($urandom_range(0, 15));
                    bus.wr_data  = v;
                    bus.wr_valid = 1'b1;
                    acc = 1'b0;
                    n = 0;
                    while (!acc && n < 400) begin
                        acc = bus.wr_ready;
                        tick;
                        n++;
                    end
                    if (!acc) check("wr_timeout", {31'd0, acc}, 32'd1);
                    exp_q.push_back(v);
                end
                bus.wr_valid = 1'b0;
            end
            begin
                for (int unsigned i = 0; i < 200; i++) begin
                    logic [3:0] g;
                    serve_token($urandom_range(0, 10), g);
                    if (exp_q.size() == 0) order_errs++;
                    else if (exp_q.pop_front() !== g) order_errs++;
                end
            end
        join
        check("rand_order",     order_errs,     0);
        check("rand_stability", stab_errs,      0);
        check("rand_rises",     rises - r0,     32'd200);
        check("rand_count",     {16'd0, cnt},   32'd200);

        // Reset while in REQ_HI with three words still queued
        do_reset(1'b0);
        write_word(4'hA);
        write_word(4'hB);
        write_word(4'hC);
        write_word(4'hD);
        check("mid_req_hi", {31'd0, bus.req_out}, 32'd1);
        bus.ack_in = 1'b1;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("mid_rst_req",   {31'd0, bus.req_out},  32'd0);
        check("mid_rst_count", {16'd0, cnt},          32'd0);
        check("mid_rst_ready", {31'd0, bus.wr_ready}, 32'd1);
        tick;
        check("mid_rst_busy",  {31'd0, busy},         32'd0);
        r0 = rises;
        repeat (5) tick;
        bus.ack_in = 1'b0;
        repeat (20) tick;
        check("mid_no_token", rises - r0,   32'd0);
        check("mid_count",    {16'd0, cnt}, 32'd0);

        // Zero setup: request rises on the pop edge; count wraps
        bus0.wr_data  = 4'h9;
        bus0.wr_valid = 1'b1;
        tick;
        bus0.wr_valid = 1'b0;
        check("z_e0_req",  {31'd0, bus0.req_out},  32'd0);
        tick;
        check("z_e1_data", {28'd0, bus0.data_out}, 32'h9);
        check("z_e1_req",  {31'd0, bus0.req_out},  32'd1);
        force dut0.sent_q = 16'hFFFF;
        tick;
        release dut0.sent_q;
        tick;
        check("z_preload", {16'd0, cnt0}, 32'hFFFF);
        bus0.ack_in = 1'b1;
        begin
            int unsigned n;
            n = 0;
            while (bus0.req_out !== 1'b0 && n < 50) begin tick; n++; end
            check("z_req_fall", {31'd0, bus0.req_out}, 32'd0);
            bus0.ack_in = 1'b0;
            n = 0;
            while (cnt0 == 16'hFFFF && n < 50) begin tick; n++; end
        end
        check("z_wrap", {16'd0, cnt0}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spike_tx.md
# spike_tx

Synchronous initiator for the neuron 4-phase bundled-data handshake: buffers input words from clocked logic in a small FIFO and presents each one to a neuron's `data_in`/`req_in`/`ack_in` input as one return-to-zero token. It sits at the boundary between the clocked stimulus/host domain and the asynchronous neuron chain, driving the first neuron of a network. The downstream neuron acknowledges every token, fired or absorbed, so every accepted word completes exactly one handshake.

## Interface
- `data_bits`, 4: token data width; matches neuron `data_bits`.
- `fifo_depth`, 4: input FIFO entries; power of two, ≥2.
- `setup_cycles`, 1: cycles `data_out` is held stable before `req_out` rises (bundling margin), 0–15.
- `sync_stages`, 2: flops in the `ack_in` synchronizer, ≥2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `wr_data`  in  data_bits  word to send.
- `wr_valid`  in  1  write strobe; accepted when `wr_valid & wr_ready` at an edge.
- `wr_ready`  out  1  FIFO not full.
- `data_out`  out  data_bits  token data to the neuron `data_in`; registered.
- `req_out`  out  1  request to the neuron `req_in`; registered, glitch-free.
- `ack_in`  in  1  acknowledge from the neuron `ack_in`; asynchronous, synchronized internally.
- `busy`  out  1  high when the FIFO is non-empty or the state is not IDLE.
- `sent_count`  out  16  completed handshakes; wraps.

## Operation
- Reset values: `req_out`=0, `data_out`=0, `sent_count`=0, FIFO empty, `wr_ready`=1, `busy`=0, state IDLE, synchronizer flops 0.
- `ack_s` is `ack_in` after `sync_stages` flops. The FSM uses only `ack_s`.
- FSM states:
  - IDLE: if the FIFO is non-empty and `ack_s`=0, pop the head into `data_out`. Go to SETUP with the counter set to `setup_cycles`. If `setup_cycles`=0, go directly to REQ_HI and set `req_out`=1 on the same edge.
  - SETUP: decrement the counter. On the edge where the counter reaches 0, set `req_out`=1 and go to REQ_HI.
  - REQ_HI: wait for `ack_s`=1, then set `req_out`=0 and go to REQ_LO.
  - REQ_LO: wait for `ack_s`=0, then increment `sent_count` and go to IDLE.
- `data_out` changes only on a pop. It is held through the complete handshake and afterwards until the next pop.
- FIFO:
  - `wr_ready` = (occupancy < `fifo_depth`). It depends on occupancy only, with no same-cycle pop pass-through.
  - A write while full is dropped, with no state change.
  - A simultaneous write and pop updates occupancy by net 0.
  - Order is strict FIFO.
- `ack_s` transitions outside the state that waits for them are ignored: a rise in IDLE or SETUP, or a fall in REQ_HI.
- `sent_count` wraps from 0xFFFF to 0.
- Mid-handshake reset:
  - `req_out` drops to 0 on the reset edge and the FIFO is flushed.
  - IDLE's `ack_s`=0 guard prevents a new token until the neuron releases ack.

## Timing
- The write accepted at edge N into an empty FIFO, with state IDLE and `ack_s`=0, is popped at edge N+1.
- `req_out` rises at edge N+1+`setup_cycles`. The default is N+2.
- `ack_in` rising between edges K-1 and K gives `ack_s`=1 after edge K+`sync_stages`-1. `req_out` falls at edge K+`sync_stages`, which is edge K+2 by default.
- `ack_in` falling is seen the same way. `sent_count` increments at edge K'+`sync_stages`, and the state is IDLE after that edge.
- The next pop is 1 edge after returning to IDLE. Minimum token period with an instant neuron is 2+`setup_cycles`+2·`sync_stages`+1 cycles, which is 8 by default.
- `busy` is registered and is valid one cycle after the write/pop edge.

## Test plan
- Single token, defaults: write 0x5 at edge 0 → `data_out`=0x5 at edge 1, `req_out`↑ at edge 2. Responder raises ack 1 cycle later → `req_out`↓ 2 edges after. Ack drops → `sent_count`=1, `busy`=0.
- Burst: write 0x1,0x2,0x3,0x4,0x5 back-to-back → `wr_ready`=0 after the 4th, 5th write dropped. Tokens arrive in order 1,2,3,4, then `sent_count`=4.
- Data stability: random responder delays 0–10 cycles on 200 tokens → `data_out` never changes while `req_out`=1 or REQ_LO; no spurious `req_out` pulses.
- Stuck ack: hold `ack_in`=1 from reset release, write 0x7 → no `req_out` until `ack_in`=0, then a normal token.
- Reset mid-handshake: assert `rst` in REQ_HI with 3 words queued → next edge `req_out`=0, FIFO empty, `sent_count`=0. Release ack → no token emitted.
- Wrap and zero setup: `setup_cycles`=0, preload `sent_count` path via 65536 tokens (or force) → count wraps to 0; `req_out` rises on the pop edge.
